// File: rtl/imem_fetch_pkg.sv
// Shared types for the instruction fetch controller: FSM states, reset PC
// and the {pc, instr} entry carried through the prefetch buffer.
package imem_fetch_pkg;

  localparam int unsigned FETCH_W = 32;
  localparam logic [FETCH_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [FETCH_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_if.sv
// ROM, redirect and decode-handshake signals of the fetch controller.
interface imem_fetch_if #(
  parameter int unsigned WIDTH = 32
);

  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rd;
  logic             redirect_valid;
  logic [WIDTH-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             align_err;

  modport master (
    output imem_addr,
    input  imem_rd,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output align_err
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  align_err
  );

endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of fetch entries with a
// combinational head; flush wins over push and pop.
module fetch_fifo
  import imem_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  fetch_entry_t           push_data,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Entry storage; writes are dropped during a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, reads the combinational
// ROM into the prefetch buffer and presents {pc, instr} to decode.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = FETCH_W,
  parameter int unsigned      DEPTH    = 2,
  parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  imem_fetch_if.master bus
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_state_t     state_r;
  fetch_state_t     state_next_s;
  logic [WIDTH-1:0] fetch_pc_r;
  logic             align_r;
  fetch_entry_t     last_r;
  fetch_entry_t     head_s;
  fetch_entry_t     push_data_s;
  logic [CNT_W-1:0] count_s;
  logic             out_valid_s;
  logic             pop_s;
  logic             fire_s;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (run) state_next_s = RUN;
        else     state_next_s = IDLE;
      end
      RUN: begin
        if (!run) state_next_s = IDLE;
        else      state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Fetch is gated by the state being entered, so the first word is
  // captured on the very edge that leaves IDLE.
  assign out_valid_s = (count_s != '0);
  assign pop_s       = out_valid_s & bus.out_ready & ~bus.redirect_valid;
  assign fire_s      = (state_next_s == RUN) & ~bus.redirect_valid
                       & ((count_s < DEPTH_C) | pop_s);
  assign push_data_s = '{pc: fetch_pc_r, instr: bus.imem_rd};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.redirect_valid),
    .push      (fire_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Fetch PC: redirect target (word aligned) beats sequential advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= {bus.redirect_pc[WIDTH-1:2], 2'b00};
    end else if (fire_s) begin
      fetch_pc_r <= fetch_pc_r + WIDTH'(32'd4);
    end
  end

  // Sticky misaligned-redirect flag and last presented head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_r <= 1'b0;
      last_r  <= '0;
    end else begin
      if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00)) begin
        align_r <= 1'b1;
      end
      if (out_valid_s) begin
        last_r <= head_s;
      end
    end
  end

  // Decode-side outputs hold the last head while the buffer is empty.
  always_comb begin
    bus.out_valid = out_valid_s;
    if (out_valid_s) begin
      bus.out_pc    = head_s.pc;
      bus.out_instr = head_s.instr;
    end else begin
      bus.out_pc    = last_r.pc;
      bus.out_instr = last_r.instr;
    end
  end

  assign bus.imem_addr = {2'b00, fetch_pc_r[WIDTH-1:2]};
  assign bus.align_err = align_r;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl against a queue-based model of the
// prefetch buffer, with directed scenarios followed by randomized traffic.
module tb_imem_fetch_ctrl;

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } m_entry_t;

  logic clk;
  logic rst_n;
  logic run;

  imem_fetch_if #(.WIDTH(32)) bus ();

  imem_fetch_ctrl #(
    .WIDTH    (32),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .bus   (bus)
  );

  // ROM word i holds 0x1000_0000 + i.
  assign bus.imem_rd = 32'h1000_0000 + bus.imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  m_entry_t    m_q[$];
  m_entry_t    m_last;
  logic [31:0] m_pc;
  logic        m_align;

  function automatic logic [31:0] rom(input logic [31:0] byte_pc);
    return 32'h1000_0000 + (byte_pc >> 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last  = '0;
    m_pc    = 32'h0000_0000;
    m_align = 1'b0;
  endtask

  task automatic check_all();
    logic     v;
    m_entry_t e;
    v = (m_q.size() != 0);
    e = v ? m_q[0] : m_last;
    check("out_valid", 32'(bus.out_valid), 32'(v));
    check("out_pc",    bus.out_pc,    e.pc);
    check("out_instr", bus.out_instr, e.instr);
    check("imem_addr", bus.imem_addr, m_pc >> 2);
    check("align_err", 32'(bus.align_err), 32'(m_align));
  endtask

  // One clock: drive inputs, advance the model over the edge, check at negedge.
  task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc);
    logic m_valid, m_pop, m_fire;
    run                = r;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    m_valid = (m_q.size() != 0);
    m_pop   = m_valid && rdy && !rv;
    m_fire  = r && !rv && ((m_q.size() < DEPTH) || m_pop);
    @(posedge clk);
    if (m_valid) m_last = m_q[0];
    if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) m_align = 1'b1;
    end else begin
      if (m_pop) void'(m_q.pop_front());
      if (m_fire) begin
        m_q.push_back('{pc: m_pc, instr: rom(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n              = 1'b0;
    run                = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all();

    // Release with decode stalled: buffer fills, fetch address freezes.
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("bp_addr_frozen", bus.imem_addr, 32'd2);
    check("bp_head_pc", bus.out_pc, 32'h0);

    // Stream one per cycle once decode accepts.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect with concurrent pop: one bubble, then the target.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    check("redir_bubble", 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_pc", bus.out_pc, 32'h0000_0040);
    check("redir_instr", bus.out_instr, 32'h1000_0010);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect sets the sticky flag and fetches aligned.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0042);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("misalign_pc", bus.out_pc, 32'h0000_0040);
    check("misalign_flag", 32'(bus.align_err), 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Run low: buffer drains and fetch PC holds.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    check("drained", 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h0);

    // Address wrap past the top of the byte space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_last", bus.out_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("wrap_zero", bus.out_pc, 32'h0000_0000);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic        r, rdy, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom() & 32'h0000_0FFF;
      step(r, rdy, rv, rpc);
    end

    // Mid-operation asynchronous reset with a full buffer.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_valid", 32'(bus.out_valid), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check("post_reset_pc", bus.out_pc, 32'h0000_0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch controller that sequences the combinational instruction ROM (`imem`). It owns the fetch PC, drives the ROM word address, captures returned words into a small prefetch buffer, and hands `{pc, instr}` pairs to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and restart fetch. It sits between `imem` and the core's decode stage.

## Interface

Parameters:
- `WIDTH`, 32, data and address width; matches `imem` WIDTH.
- `DEPTH`, 2, prefetch buffer entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  fetch enable; low stops new fetches, buffer still drains.
- `imem_addr`  out  WIDTH  word index to `imem` (= `fetch_pc >> 2`).
- `imem_rd`  in  WIDTH  combinational ROM data for `imem_addr`.
- `redirect_valid`  in  1  one-cycle request to restart fetch.
- `redirect_pc`  in  WIDTH  byte target address for redirect.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts head this cycle.
- `out_instr`  out  WIDTH  head instruction word.
- `out_pc`  out  WIDTH  byte address of head instruction.
- `align_err`  out  1  sticky; set when a redirect target has `pc[1:0] != 0`.

## Operation

- FSM `IDLE`, `RUN`. Reset → `IDLE`. `IDLE`→`RUN` when `run`=1; `RUN`→`IDLE` when `run`=0. Redirect is honoured in both states.
- `fetch_pc` is a byte address; `imem_addr = {2'b00, fetch_pc[WIDTH-1:2]}` combinationally.
- Fetch fires in a cycle when state=`RUN`, no redirect, and (count < DEPTH, or count = DEPTH with a pop this cycle). On fire: push `{fetch_pc, imem_rd}`, `fetch_pc += 4`, wrapping modulo 2^WIDTH.
- Pop = `out_valid & out_ready`. Push and pop in the same cycle leave count unchanged.
- Redirect: buffer cleared (count→0), `fetch_pc ← {redirect_pc[WIDTH-1:2], 2'b00}`, no push that cycle. Redirect overrides a simultaneous pop and fetch. The head presented during that cycle is discarded even when `out_ready`=1.
- `align_err` is set on a redirect with misaligned target and is cleared only by reset.
- Outputs when `out_valid`=0: `out_instr` and `out_pc` hold the last head value. Decode must ignore them.

## Timing

- Reset values: state `IDLE`, `fetch_pc` = `RESET_PC`, count 0, `out_valid` 0, `out_instr` 0, `out_pc` 0, `align_err` 0, `imem_addr` = `RESET_PC >> 2`.
- Fetch-to-output latency is 1 cycle. A word captured at edge N is visible on `out_*` after edge N with `out_valid`=1.
- With `run`=1 from reset release and `out_ready` held high, `out_valid` rises after the first edge and stays high, giving one instruction per cycle.
- After a redirect at edge N, `out_valid` is 0 for the following cycle. The target instruction appears after edge N+1.
- A full buffer with `out_ready`=0 stalls fetch. `fetch_pc` and `imem_addr` are stable.
- A `rst_n` assertion mid-operation clears everything immediately (asynchronous). The first fetch after release is from `RESET_PC`.

## Structure

- Package `imem_fetch_pkg` holds the state enum (`IDLE`, `RUN`), `RESET_PC` default, and the `fetch_entry_t` struct `{pc, instr}`.
- Sub-module `fetch_fifo`:
  - DEPTH-entry synchronous FIFO of `fetch_entry_t` with push, pop and flush.
  - Head is read combinationally.
  - Count width is `$clog2(DEPTH)+1`.
  - Flush has priority over push and pop.
- Top module holds the FSM, `fetch_pc`, align check and handshake glue. `imem` is instantiated outside.

## Test plan

- Reset and stream: ROM words i = 32'h1000_0000+i, `run`=1, `out_ready`=1. Expect `out_pc` 0,4,8,… and `out_instr` 1000_0000,1000_0001,… one per cycle from the first edge.
- Backpressure: `out_ready`=0 for 5 cycles. Expect count saturates at DEPTH, `imem_addr` frozen at 2, and no word skipped or duplicated after `out_ready` returns to 1.
- Redirect with concurrent pop: `redirect_valid`=1 with `redirect_pc`=0x40 while `out_ready`=1. Expect one bubble cycle (`out_valid`=0), then `out_pc`=0x40 and `out_instr`=ROM[16].
- Misaligned redirect: `redirect_pc`=0x42. Expect `align_err`=1 (sticky), fetch from 0x40, `out_pc`=0x40.
- Run gating and wrap:
  - `run`=0 mid-stream: the buffer drains, then `out_valid`=0 and `fetch_pc` holds.
  - Redirect to 0xFFFF_FFFC: the next `out_pc` after 0xFFFF_FFFC is 0x0000_0000.
- Mid-operation reset: assert `rst_n`=0 asynchronously with a full buffer. Expect `out_valid`=0 immediately, and `out_pc`=`RESET_PC` as the first output after release.
